// File: rtl/slv_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | slv_pkg -- shared types for the subordinate guard reset controller         |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package slv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_ACK    = 3'd4
    } slv_rst_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slv_guard_rst_tmr.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | slv_guard_rst_tmr -- loadable down-counter with zero flag                  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module slv_guard_rst_tmr #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic             zero
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    // Load wins over decrement; the count parks at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/slv_guard_rst_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | slv_guard_rst_ctrl -- drain / hold / settle / ack reset sequencer for a    |
// | guarded subordinate. Optional completed-sequence counter: define          |
// | SLV_GUARD_RST_CNT_EN.                                                     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module slv_guard_rst_ctrl
    import slv_pkg::*;
#(
    parameter int DrainCycles  = 16,
    parameter int HoldCycles   = 4,
    parameter int SettleCycles = 2,
    parameter int CntWidth     = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_req_i,
    input  logic sub_idle_i,
    output logic isolate_o,
    output logic sub_rst_no,
    output logic rst_stat_o,
    output logic busy_o,
    output logic fault_o
`ifdef SLV_GUARD_RST_CNT_EN
    ,
    output logic [CntWidth-1:0] rst_cnt_o
`endif
);

    localparam int c_MAX_CYCLES = max3(DrainCycles, HoldCycles, SettleCycles);
    localparam int c_TMR_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_TMR_W-1:0] c_DRAIN_LD  = c_TMR_W'(DrainCycles - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LD   = c_TMR_W'(HoldCycles - 1);
    localparam logic [c_TMR_W-1:0] c_SETTLE_LD = c_TMR_W'(SettleCycles - 1);

    if ((DrainCycles < 1) || (HoldCycles < 1) || (SettleCycles < 1) || (CntWidth < 1)) begin : g_param_check
        $error("slv_guard_rst_ctrl: cycle counts and CntWidth must be >= 1");
    end

    slv_rst_state_e       r_state;
    slv_rst_state_e       w_state_d;
    logic                 r_req_q;
    logic                 w_tmr_load;
    logic [c_TMR_W-1:0]   w_tmr_value;
    logic                 w_tmr_en;
    logic                 w_tmr_zero;
    logic                 w_set_fault;

    logic r_isolate;
    logic r_sub_rst_n;
    logic r_stat;
    logic r_busy;
    logic r_fault;

    slv_guard_rst_tmr #(
        .WIDTH (c_TMR_W)
    ) u_tmr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (w_tmr_load),
        .value (w_tmr_value),
        .en    (w_tmr_en),
        .zero  (w_tmr_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // The timer is reloaded on every state entry, so each phase counts from its own length.
    always_comb begin
        w_state_d   = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        w_tmr_en    = 1'b0;
        w_set_fault = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (rst_req_i && !r_req_q) begin
                    w_state_d   = ST_DRAIN;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_DRAIN_LD;
                end
            end
            ST_DRAIN: begin
                if (sub_idle_i || w_tmr_zero) begin
                    w_state_d   = ST_HOLD;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_HOLD_LD;
                    w_set_fault = !sub_idle_i;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_tmr_zero) begin
                    w_state_d   = ST_SETTLE;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = c_SETTLE_LD;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero) begin
                    w_state_d = ST_ACK;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_ACK: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req_q     <= 1'b0;
            r_isolate   <= 1'b0;
            r_sub_rst_n <= 1'b1;
            r_stat      <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_req_q     <= rst_req_i;
            r_isolate   <= (w_state_d != ST_IDLE);
            r_sub_rst_n <= (w_state_d != ST_HOLD);
            r_stat      <= (w_state_d == ST_ACK);
            r_busy      <= (w_state_d != ST_IDLE);
            r_fault     <= r_fault | w_set_fault;
        end
    end

    assign isolate_o  = r_isolate;
    assign sub_rst_no = r_sub_rst_n;
    assign rst_stat_o = r_stat;
    assign busy_o     = r_busy;
    assign fault_o    = r_fault;

`ifdef SLV_GUARD_RST_CNT_EN
    localparam logic [CntWidth-1:0] c_CNT_ONE = CntWidth'(1);

    logic [CntWidth-1:0] r_rst_cnt;

    // Bumps together with the completion pulse and saturates at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rst_cnt <= '0;
        end else if ((w_state_d == ST_ACK) && (r_rst_cnt != '1)) begin
            r_rst_cnt <= r_rst_cnt + c_CNT_ONE;
        end
    end

    assign rst_cnt_o = r_rst_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slv_guard_rst_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_slv_guard_rst_ctrl -- directed pins plus randomized run against a       |
// | timeline model of the reset sequence.  Rev 1.0                            |
// +---------------------------------------------------------------------------+
module tb_slv_guard_rst_ctrl;

    localparam int DR = 16;
    localparam int HO = 4;
    localparam int SE = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic rst_req_i = 1'b0;
    logic sub_idle_i = 1'b1;
    logic isolate_o, sub_rst_no, rst_stat_o, busy_o, fault_o;
`ifdef SLV_GUARD_RST_CNT_EN
    logic [CW-1:0] rst_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    slv_guard_rst_ctrl #(
        .DrainCycles  (DR),
        .HoldCycles   (HO),
        .SettleCycles (SE),
        .CntWidth     (CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rst_req_i  (rst_req_i),
        .sub_idle_i (sub_idle_i),
        .isolate_o  (isolate_o),
        .sub_rst_no (sub_rst_no),
        .rst_stat_o (rst_stat_o),
        .busy_o     (busy_o),
        .fault_o    (fault_o)
`ifdef SLV_GUARD_RST_CNT_EN
        ,
        .rst_cnt_o  (rst_cnt_o)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a sequence is described by the cycle it entered drain and the cycle it entered hold.
    int   cyc = 0;
    int   m_start = -1;
    int   m_hold = -1;
    logic m_fault = 1'b0;
    logic m_hist = 1'b0;
    int   m_cnt = 0;
    bit   m_valid = 1'b0;

    always @(posedge clk) begin
        bit e_seen;
        if (rst_i) begin
            m_start = -1;
            m_hold  = -1;
            m_fault = 1'b0;
            m_hist  = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b1;
        end else begin
            e_seen = rst_req_i && !m_hist;
            m_hist = rst_req_i;
            if (m_start < 0) begin
                if (e_seen) m_start = cyc + 1;
            end else if (m_hold < 0) begin
                if (sub_idle_i) begin
                    m_hold = cyc + 1;
                end else if (cyc - m_start + 1 == DR) begin
                    m_hold  = cyc + 1;
                    m_fault = 1'b1;
                end
            end else if (cyc - m_hold == HO + SE) begin
                m_start = -1;
                m_hold  = -1;
            end
            if (m_hold >= 0 && (cyc + 1 - m_hold) == HO + SE && m_cnt < (1 << CW) - 1)
                m_cnt++;
        end
        cyc++;
    end

    // Returns {isolate, sub_rst_n, stat, busy} for cycle c.
    function automatic logic [3:0] exp_out(input int c);
        int off;
        if (m_start < 0) return 4'b0100;
        if (m_hold < 0)  return 4'b1101;
        off = c - m_hold;
        if (off < HO)      return 4'b1001;
        if (off < HO + SE) return 4'b1101;
        return 4'b1111;
    endfunction

    always @(negedge clk) begin
        logic [3:0] e;
        if (m_valid) begin
            e = exp_out(cyc);
            chk("m_isolate", isolate_o, e[3]);
            chk("m_sub_rst_n", sub_rst_no, e[2]);
            chk("m_rst_stat", rst_stat_o, e[1]);
            chk("m_busy", busy_o, e[0]);
            chk("m_fault", fault_o, m_fault);
`ifdef SLV_GUARD_RST_CNT_EN
            chk("m_rst_cnt", rst_cnt_o, m_cnt);
`endif
        end
    end

    task automatic step(input logic r, input logic q, input logic i);
        rst_i      = r;
        rst_req_i  = q;
        sub_idle_i = i;
        @(negedge clk);
    endtask

    task automatic wait_idle(input logic i);
        bit done = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            if (!busy_o) done = 1'b1;
            else step(1'b0, 1'b0, i);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_idle: busy_o=%0b after 64 cycles, expected 0", busy_o);
        end
    endtask

    initial begin
        logic q;
        int   idle_pct;

        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_isolate", isolate_o, 0);
        chk("rst_sub_rst_n", sub_rst_no, 1);
        chk("rst_stat", rst_stat_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fault", fault_o, 0);

        // Nominal sequence with request held high well past ACK.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("d1_busy", busy_o, (k <= 8));
            chk("d1_sub_rst_n", sub_rst_no, !(k >= 2 && k <= 5));
            chk("d1_stat", rst_stat_o, (k == 8));
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("d1_second_busy", busy_o, 1);
        wait_idle(1'b1);
`ifdef SLV_GUARD_RST_CNT_EN
        chk("d1_cnt_two", rst_cnt_o, 2);
`endif

        // Drain timeout; fault stays set after the sequence.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            step(1'b0, (k == 1), 1'b0);
            chk("d2_fault", fault_o, (k >= 17));
            chk("d2_sub_rst_n", sub_rst_no, !(k >= 17 && k <= 20));
            chk("d2_stat", rst_stat_o, (k == 23));
            chk("d2_busy", busy_o, (k <= 23));
        end

        // Reset during hold aborts with no completion pulse.
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("d3_in_hold", sub_rst_no, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("d3_sub_rst_n", sub_rst_no, 1);
        chk("d3_isolate", isolate_o, 0);
        chk("d3_busy", busy_o, 0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("d3_no_stat", rst_stat_o, 0);
        end
`ifdef SLV_GUARD_RST_CNT_EN
        chk("d3_cnt_zero", rst_cnt_o, 0);
`endif

        // Request already high in the first cycle after reset counts as an edge.
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("d4_post_rst_edge", busy_o, 1);
        wait_idle(1'b1);

`ifdef SLV_GUARD_RST_CNT_EN
        step(1'b1, 1'b0, 1'b1);
        for (int s = 0; s < 5; s++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b1, 1'b1);
            wait_idle(1'b1);
        end
        chk("d5_cnt_sat", rst_cnt_o, 3);
`endif

        // Randomized run.
        q = 1'b0;
        idle_pct = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 256 == 0) idle_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 5) == 0) q = ~q;
            step(($urandom_range(0, 199) == 0), q, ($urandom_range(0, 99) < idle_pct));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slv_guard_rst_ctrl.md
SLV_GUARD_RST_CTRL -- requirements
Module: slv_guard_rst_ctrl

Interface
REQ-001 SHALL use a single clock; reset SHALL be synchronous and active-high.
REQ-002 SHALL have parameter DrainCycles, default 16, maximum cycles to wait for the subordinate to go idle (>=1).
REQ-003 SHALL have parameter HoldCycles, default 4, number of cycles sub_rst_no is held low (>=1).
REQ-004 SHALL have parameter SettleCycles, default 2, number of post-reset settle cycles before acknowledge (>=1).
REQ-005 SHALL have parameter CntWidth, default 8, width of the sequence counter.
REQ-006 SHALL have port clk_i, input, 1, clock.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port rst_req_i, input, 1, reset request from the guard, i.e. its rst_req_o.
REQ-009 SHALL have port sub_idle_i, input, 1, subordinate reports no outstanding transactions.
REQ-010 SHALL have port isolate_o, output, 1, guard/subordinate isolation active.
REQ-011 SHALL have port sub_rst_no, output, 1, active-low reset to the subordinate.
REQ-012 SHALL have port rst_stat_o, output, 1, one-cycle completion pulse to the guard's rst_stat_i.
REQ-013 SHALL have port busy_o, output, 1, a sequence is in progress.
REQ-014 SHALL have port fault_o, output, 1, sticky drain-timeout flag.
REQ-015 SHALL have port rst_cnt_o, output, CntWidth, completed-sequence count (present only per REQ-031).

Function
REQ-016 SHALL implement the FSM states IDLE, DRAIN, HOLD, SETTLE and ACK; all outputs SHALL be registered and decoded from the state.
REQ-017 In IDLE, a rising edge of rst_req_i (rst_req_i=1 and its registered previous value =0) SHALL move the FSM to DRAIN; a level held from a previous sequence SHALL NOT retrigger.
REQ-018 In DRAIN, sub_idle_i=1 SHALL move the FSM to HOLD on the next cycle; otherwise, after DrainCycles cycles in DRAIN, the FSM SHALL move to HOLD and set fault_o.
REQ-019 HOLD SHALL last exactly HoldCycles cycles and SETTLE exactly SettleCycles cycles, then the FSM SHALL move to ACK.
REQ-020 ACK SHALL last exactly one cycle and then return to IDLE.
REQ-021 Output values per state SHALL be: isolate_o=1 in DRAIN, HOLD, SETTLE and ACK; sub_rst_no=0 only in HOLD; rst_stat_o=1 only in ACK; busy_o=1 whenever the state is not IDLE.
REQ-022 Latency: an edge sampled at cycle t with sub_idle_i=1 SHALL give DRAIN at t+1, HOLD at t+2..t+1+HoldCycles, and ACK at t+2+HoldCycles+SettleCycles.
REQ-023 Request edges while busy SHALL be ignored and SHALL NOT be queued.
REQ-024 A single shared down-counter SHALL be loaded on each state entry; its width SHALL be $clog2(max(DrainCycles,HoldCycles,SettleCycles)+1).
REQ-025 fault_o SHALL be sticky until rst_i and SHALL NOT block further sequences.
REQ-026 If rst_req_i deasserts mid-sequence, the sequence SHALL still complete.

Reset
REQ-027 On rst_i=1, on the next clock edge the FSM SHALL enter IDLE, the counter and the rst_req_i history SHALL clear, and fault_o and rst_cnt_o SHALL clear.
REQ-028 Reset-state outputs SHALL be isolate_o=0, sub_rst_no=1, rst_stat_o=0 and busy_o=0.
REQ-029 Reset asserted mid-sequence SHALL abort the sequence, release sub_rst_no on the next cycle, and emit no rst_stat_o pulse.
REQ-030 If rst_req_i is high during the first cycle after reset, that SHALL count as a rising edge.

Configuration
REQ-031 With macro SLV_GUARD_RST_CNT_EN defined, rst_cnt_o SHALL increment by 1 in each ACK cycle and saturate at all-ones.
REQ-032 Without SLV_GUARD_RST_CNT_EN defined, port rst_cnt_o and its register SHALL be absent.

Structure
REQ-033 The state enum slv_rst_state_e SHALL live in the shared package slv_pkg.
REQ-034 The loadable down-counter SHALL be one sub-module named slv_guard_rst_tmr, with inputs load, value and en, and output zero.

Verification
REQ-035 Hold=4, Settle=2, sub_idle_i=1, edge at cycle 10 -> DRAIN at 11; sub_rst_no=0 at cycles 12-15; rst_stat_o=1 at cycle 18 only; busy_o=0 at 19.
REQ-036 Drain=16, sub_idle_i=0 throughout -> HOLD entered after 16 DRAIN cycles; fault_o=1 and stays 1 after ACK.
REQ-037 rst_req_i held high across ACK and beyond -> exactly one sequence; a second edge after a low cycle -> second sequence, rst_cnt_o=2.
REQ-038 rst_i pulsed during HOLD -> sub_rst_no=1 and isolate_o=0 next cycle; no rst_stat_o pulse; rst_cnt_o=0.
REQ-039 CntWidth=2, five sequences with the macro defined -> rst_cnt_o saturates at 3.
